serdes_align_ctrl: RTL and testbench
====================================

Name: serdes_align_ctrl

Overview:
Link-training controller for the 8:1 source-synchronous SERDES receive path (ISERDESE3 lanes, sync lane, rx alignment gearbox).
- Sequences ISERDES reset after rx PLL lock.
- Derives the gearbox bit shift from the one-hot sync-lane word.
- Qualifies alignment against the incrementing-counter training pattern, then monitors the locked link and retrains on loss.
- Runs in the rxdivclk domain; drives the gearbox `shift` select and the ISERDES reset.

Parameters:
N, 3, number of 8-bit data lanes.
RST_CYCLES, 16, ISERDES reset hold cycles.
MATCH_CNT, 8, consecutive identical one-hot sync words required to accept a shift.
SETTLE, 4, cycles after a shift update during which data compare is disabled (covers gearbox latency).
CHECK_CYCLES, 64, consecutive good data compares required to declare lock.
LOSS_CNT, 4, consecutive bad sync words in LOCKED that force a re-search.
TIMEOUT, 1024, max cycles spent in SEARCH+CHECK before retry via RESET.

Ports:
clk  in  1  rxdivclk domain clock.
rstn  in  1  asynchronous active-low reset.
pll_locked  in  1  rx PLL locked; async-origin, double-flop synchronised internally.
rxsync  in  8  sync-lane ISERDES word.
rx_dout  in  8*N  gearbox output, lane i = bits [8i+7:8i].
retrain  in  1  single-cycle request to restart training.
serdes_rst  out  1  ISERDES reset, active-high.
shift  out  3  gearbox shift select.
aligned  out  1  high only in LOCKED.
error  out  1  one-cycle pulse per data miscompare in LOCKED.
err_count  out  16  saturating miscompare count.
retry_count  out  8  saturating count of TIMEOUT retries.
state  out  3  IDLE=0, RESET=1, SEARCH=2, CHECK=3, LOCKED=4.

Behaviour:
- Reset values (rstn low): state=IDLE, serdes_rst=1, shift=0, aligned=0, error=0, err_count=0, retry_count=0, all internal counters 0. All outputs are registered.
- Sync decode: exactly one bit set -> valid, index = bit position. Any other value, including 0 or multiple bits set -> invalid.
- Compare: per lane, rx_dout[i] == prev[i]+1 mod 256, where prev is the previous cycle's lane value. The compare is valid only when prev was captured in the immediately preceding cycle. All N lanes must pass for a cycle to count as good.
- Priority, highest first:
  1. Synchronised pll_locked=0 -> IDLE, from any state.
  2. retrain=1 -> RESET, from any state except IDLE. Also clears err_count and retry_count.
  3. Per-state transitions below.
- IDLE: serdes_rst=1, aligned=0. On synced pll_locked=1 -> RESET.
- RESET: serdes_rst=1 for exactly RST_CYCLES cycles, then -> SEARCH with serdes_rst=0 on the same edge. Clears the match, settle, check and timeout counters.
- SEARCH:
  - Valid sync equal to the current candidate: match++.
  - Valid sync different from the candidate: candidate <= index, match=1.
  - Invalid sync: match=0.
  - When match reaches MATCH_CNT: shift <= candidate, -> CHECK, load the settle counter.
- CHECK:
  - The first SETTLE cycles ignore compares.
  - After that, each good compare increments the good counter.
  - Any bad compare -> SEARCH with match=0.
  - Good counter reaching CHECK_CYCLES -> LOCKED, aligned=1 on the same edge.
- Timeout: the counter runs only in SEARCH and CHECK and is not cleared between them. Reaching TIMEOUT -> RESET and retry_count++ (saturates at 255).
- LOCKED:
  - Bad compare: error=1 for that one cycle, err_count++ (saturates at 0xFFFF). State is unchanged.
  - Sync word != onehot(shift): loss++. Matching word: loss=0.
  - loss reaching LOSS_CNT -> SEARCH, aligned=0, error=0.
- shift holds its value in every state except the SEARCH->CHECK edge. It is reset to 0 only by rstn.
- pll_locked dropping mid-operation: the synchroniser adds 2 cycles of latency, then state goes to IDLE. Counters are cleared; err_count and retry_count are kept.

Test Plan:
- Clean link, sync=8'b0000_0100 constant, lanes increment from 0 → SEARCH exits after 8 cycles; shift=2; aligned=1 exactly SETTLE+64 cycles later; error never asserts.
- Hold pll_locked low for 20 cycles, then raise it → serdes_rst stays 1 until 2+16 cycles after the rise; state sequence is 0→1→2.
- In LOCKED, corrupt lane 1 on a single cycle → error pulses twice (corrupted value, then the following value vs the corrupted prev); err_count=2; aligned stays 1.
- In LOCKED, sync=0 for 3 cycles then correct → still LOCKED. Sync=0 for 4 cycles → SEARCH, aligned=0.
- Sync toggles between bit 1 and bit 5 every 4 cycles → no lock; after 1024 cycles state=RESET and retry_count=1.
- Assert retrain in CHECK, and separately assert rstn low in LOCKED → CHECK case goes to RESET next cycle with err_count=0; rstn case returns all outputs to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/serdes_align_ctrl.sv
// Link-training controller for the 8:1 SERDES receive path.
// It holds the ISERDES in reset after the rx PLL locks, then picks the gearbox
// shift from the one-hot sync lane. It qualifies that shift against the
// incrementing-counter training data and monitors the locked link.

// Per-lane increment checker: remembers the last word and flags word == last+1.
module serdes_align_lane (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic       i_cap,
  input  logic [7:0] i_din,
  output logic       o_inc
);
  logic [7:0] r_prev;

  // capture the lane word whenever the controller is active
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn)    r_prev <= '0;
    else if (i_cap) r_prev <= i_din;
  end

  assign o_inc = (i_din == r_prev + 8'd1);
endmodule

module serdes_align_ctrl #(
  parameter int N            = 3,
  parameter int RST_CYCLES   = 16,
  parameter int MATCH_CNT    = 8,
  parameter int SETTLE       = 4,
  parameter int CHECK_CYCLES = 64,
  parameter int LOSS_CNT     = 4,
  parameter int TIMEOUT      = 1024
) (
  input  logic           i_clk,
  input  logic           i_rstn,
  input  logic           i_pll_locked,
  input  logic [7:0]     i_rxsync,
  input  logic [8*N-1:0] i_rx_dout,
  input  logic           i_retrain,
  output logic           o_serdes_rst,
  output logic [2:0]     o_shift,
  output logic           o_aligned,
  output logic           o_error,
  output logic [15:0]    o_err_count,
  output logic [7:0]     o_retry_count,
  output logic [2:0]     o_state
);
  localparam int RW = $clog2(RST_CYCLES + 1);
  localparam int MW = $clog2(MATCH_CNT + 1);
  localparam int SW = $clog2(SETTLE + 1);
  localparam int GW = $clog2(CHECK_CYCLES + 1);
  localparam int LW = $clog2(LOSS_CNT + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RESET  = 3'd1,
    SEARCH = 3'd2,
    CHECK  = 3'd3,
    LOCKED = 3'd4
  } state_t;

  state_t      r_state, w_state_nxt;
  logic        r_pll_meta, r_pll_sync;
  logic [RW-1:0] r_rst_cnt, w_rst_cnt_nxt;
  logic [MW-1:0] r_match, w_match_nxt, w_match_c;
  logic [2:0]  r_cand, w_cand_nxt;
  logic [SW-1:0] r_settle, w_settle_nxt;
  logic [GW-1:0] r_good, w_good_nxt;
  logic [LW-1:0] r_loss, w_loss_nxt, w_loss_c;
  logic [TW-1:0] r_to, w_to_nxt, w_to_inc;
  logic [2:0]  r_shift, w_shift_nxt;
  logic        r_error, w_error_nxt;
  logic [15:0] r_err_cnt, w_err_cnt_nxt;
  logic [7:0]  r_retry, w_retry_nxt;
  logic        r_serdes_rst, r_aligned;
  logic        r_prev_vld;

  logic        w_cap, w_good;
  logic [N-1:0] w_lane_inc;
  logic [2:0]  w_sync_idx;
  logic [3:0]  w_sync_ones;
  logic        w_sync_vld;
  logic [7:0]  w_shift_oh;

  // pll_locked comes from another domain; two flops before anything uses it
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_pll_meta <= 1'b0;
      r_pll_sync <= 1'b0;
    end else begin
      r_pll_meta <= i_pll_locked;
      r_pll_sync <= r_pll_meta;
    end
  end

  // lane history is only meaningful while training/monitoring is running
  assign w_cap = (r_state != IDLE);

  for (genvar g = 0; g < N; g++) begin : g_lane
    serdes_align_lane u_lane (
      .i_clk  (i_clk),
      .i_rstn (i_rstn),
      .i_cap  (w_cap),
      .i_din  (i_rx_dout[8*g +: 8]),
      .o_inc  (w_lane_inc[g])
    );
  end

  // a compare counts only if every lane has a previous-cycle word to diff against
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) r_prev_vld <= 1'b0;
    else         r_prev_vld <= w_cap;
  end

  assign w_good = r_prev_vld & (&w_lane_inc);

  // sync word decode: exactly one set bit gives a valid shift index
  always_comb begin
    w_sync_idx  = '0;
    w_sync_ones = '0;
    for (int b = 0; b < 8; b++) begin
      if (i_rxsync[b]) begin
        w_sync_idx  = 3'(b);
        w_sync_ones = w_sync_ones + 4'd1;
      end
    end
  end

  assign w_sync_vld = (w_sync_ones == 4'd1);
  assign w_shift_oh = 8'd1 << r_shift;
  assign w_to_inc   = r_to + TW'(1);

  // next-state and next-counter logic; pll loss beats retrain beats per-state
  always_comb begin
    w_state_nxt   = r_state;
    w_rst_cnt_nxt = r_rst_cnt;
    w_match_nxt   = r_match;
    w_cand_nxt    = r_cand;
    w_settle_nxt  = r_settle;
    w_good_nxt    = r_good;
    w_loss_nxt    = r_loss;
    w_to_nxt      = r_to;
    w_shift_nxt   = r_shift;
    w_error_nxt   = 1'b0;
    w_err_cnt_nxt = r_err_cnt;
    w_retry_nxt   = r_retry;
    w_match_c     = '0;
    w_loss_c      = '0;

    if (!r_pll_sync) begin
      w_state_nxt   = IDLE;
      w_rst_cnt_nxt = '0;
      w_match_nxt   = '0;
      w_settle_nxt  = '0;
      w_good_nxt    = '0;
      w_loss_nxt    = '0;
      w_to_nxt      = '0;
    end else if (i_retrain && (r_state != IDLE)) begin
      w_state_nxt   = RESET;
      w_rst_cnt_nxt = '0;
      w_match_nxt   = '0;
      w_settle_nxt  = '0;
      w_good_nxt    = '0;
      w_loss_nxt    = '0;
      w_to_nxt      = '0;
      w_err_cnt_nxt = '0;
      w_retry_nxt   = '0;
    end else begin
      case (r_state)
        IDLE: w_state_nxt = RESET;

        RESET: begin
          if (r_rst_cnt == RW'(RST_CYCLES - 1)) begin
            w_state_nxt   = SEARCH;
            w_rst_cnt_nxt = '0;
            w_match_nxt   = '0;
            w_to_nxt      = '0;
          end else begin
            w_rst_cnt_nxt = r_rst_cnt + RW'(1);
          end
        end

        SEARCH, CHECK: begin
          if (w_to_inc == TW'(TIMEOUT)) begin
            // training is stuck: start over from the ISERDES reset
            w_state_nxt  = RESET;
            w_match_nxt  = '0;
            w_settle_nxt = '0;
            w_good_nxt   = '0;
            w_to_nxt     = '0;
            w_retry_nxt  = (r_retry != 8'hFF) ? r_retry + 8'd1 : r_retry;
          end else begin
            w_to_nxt = w_to_inc;
            if (r_state == SEARCH) begin
              if (!w_sync_vld) begin
                w_match_c = '0;
              end else if (w_sync_idx == r_cand) begin
                w_match_c = r_match + MW'(1);
              end else begin
                w_match_c  = MW'(1);
                w_cand_nxt = w_sync_idx;
              end
              w_match_nxt = w_match_c;
              if (w_match_c == MW'(MATCH_CNT)) begin
                w_state_nxt  = CHECK;
                w_shift_nxt  = w_cand_nxt;
                w_match_nxt  = '0;
                w_settle_nxt = SW'(SETTLE);
                w_good_nxt   = '0;
              end
            end else begin
              // gearbox output is stale for SETTLE cycles after a shift change
              if (r_settle != '0) begin
                w_settle_nxt = r_settle - SW'(1);
              end else if (!w_good) begin
                w_state_nxt = SEARCH;
                w_match_nxt = '0;
                w_good_nxt  = '0;
              end else if (r_good + GW'(1) == GW'(CHECK_CYCLES)) begin
                w_state_nxt = LOCKED;
                w_good_nxt  = '0;
                w_loss_nxt  = '0;
                w_to_nxt    = '0;
              end else begin
                w_good_nxt = r_good + GW'(1);
              end
            end
          end
        end

        LOCKED: begin
          w_loss_c = (i_rxsync == w_shift_oh) ? '0 : r_loss + LW'(1);
          if (w_loss_c == LW'(LOSS_CNT)) begin
            w_state_nxt = SEARCH;
            w_loss_nxt  = '0;
            w_match_nxt = '0;
          end else begin
            w_loss_nxt = w_loss_c;
            if (!w_good) begin
              w_error_nxt   = 1'b1;
              w_err_cnt_nxt = (r_err_cnt != 16'hFFFF) ? r_err_cnt + 16'd1 : r_err_cnt;
            end
          end
        end

        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // state, counters and registered outputs
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state      <= IDLE;
      r_rst_cnt    <= '0;
      r_match      <= '0;
      r_cand       <= '0;
      r_settle     <= '0;
      r_good       <= '0;
      r_loss       <= '0;
      r_to         <= '0;
      r_shift      <= '0;
      r_error      <= 1'b0;
      r_err_cnt    <= '0;
      r_retry      <= '0;
      r_serdes_rst <= 1'b1;
      r_aligned    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_rst_cnt    <= w_rst_cnt_nxt;
      r_match      <= w_match_nxt;
      r_cand       <= w_cand_nxt;
      r_settle     <= w_settle_nxt;
      r_good       <= w_good_nxt;
      r_loss       <= w_loss_nxt;
      r_to         <= w_to_nxt;
      r_shift      <= w_shift_nxt;
      r_error      <= w_error_nxt;
      r_err_cnt    <= w_err_cnt_nxt;
      r_retry      <= w_retry_nxt;
      r_serdes_rst <= (w_state_nxt == IDLE) || (w_state_nxt == RESET);
      r_aligned    <= (w_state_nxt == LOCKED);
    end
  end

  assign o_state       = r_state;
  assign o_serdes_rst  = r_serdes_rst;
  assign o_shift       = r_shift;
  assign o_aligned     = r_aligned;
  assign o_error       = r_error;
  assign o_err_count   = r_err_cnt;
  assign o_retry_count = r_retry;
endmodule

// File: tb/tb_serdes_align_ctrl.sv
// Bench for serdes_align_ctrl: directed link-training scenarios plus a random
// soak. Every cycle is checked against a cycle-level reference model.
module tb_serdes_align_ctrl;
  localparam int N = 3;

  logic           i_clk = 1'b0;
  logic           i_rstn, i_pll_locked, i_retrain;
  logic [7:0]     i_rxsync;
  logic [8*N-1:0] i_rx_dout;
  logic           o_serdes_rst, o_aligned, o_error;
  logic [2:0]     o_shift, o_state;
  logic [15:0]    o_err_count;
  logic [7:0]     o_retry_count;

  serdes_align_ctrl #(.N(N)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_pll_locked(i_pll_locked),
    .i_rxsync(i_rxsync), .i_rx_dout(i_rx_dout), .i_retrain(i_retrain),
    .o_serdes_rst(o_serdes_rst), .o_shift(o_shift), .o_aligned(o_aligned),
    .o_error(o_error), .o_err_count(o_err_count),
    .o_retry_count(o_retry_count), .o_state(o_state)
  );

  always #5 i_clk = ~i_clk;

  int n_chk = 0, n_pass = 0, cyc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // reference model: states as plain ints, reset hold as a countdown,
  // data check as modular differences
  int m_st, m_rst_left, m_run, m_cand, m_settle, m_goodrun, m_loss, m_spent;
  int m_shift, m_errs, m_retries, m_prev[N];
  bit m_pll0, m_pll1, m_pvld;
  int e_state; bit e_srst, e_al, e_err;

  task automatic m_clr();
    m_rst_left = 16; m_run = 0; m_settle = 0; m_goodrun = 0; m_loss = 0; m_spent = 0;
  endtask

  task automatic model_reset();
    m_clr();
    m_st = 0; m_cand = 0; m_shift = 0; m_errs = 0; m_retries = 0;
    m_pll0 = 0; m_pll1 = 0; m_pvld = 0;
    for (int i = 0; i < N; i++) m_prev[i] = 0;
  endtask

  task automatic model_step();
    int ns, cur, ones, idx;
    bit good, err;
    good = m_pvld;
    for (int i = 0; i < N; i++) begin
      cur = int'(i_rx_dout[8*i +: 8]);
      if (((cur - m_prev[i]) & 255) != 1) good = 0;
    end
    ones = $countones(i_rxsync);
    idx = 0;
    for (int b = 0; b < 8; b++) if (i_rxsync[b]) idx = b;
    err = 0; ns = m_st;
    if (!m_pll1) begin ns = 0; m_clr(); end
    else if (i_retrain && m_st != 0) begin ns = 1; m_clr(); m_errs = 0; m_retries = 0; end
    else case (m_st)
      0: begin ns = 1; m_clr(); end
      1: begin m_rst_left--; if (m_rst_left == 0) begin ns = 2; m_clr(); end end
      2, 3: begin
        m_spent++;
        if (m_spent == 1024) begin
          ns = 1; m_clr();
          if (m_retries < 255) m_retries++;
        end else if (m_st == 2) begin
          if (ones != 1) m_run = 0;
          else if (idx == m_cand) m_run++;
          else begin m_cand = idx; m_run = 1; end
          if (m_run == 8) begin ns = 3; m_shift = m_cand; m_run = 0; m_settle = 4; m_goodrun = 0; end
        end else begin
          if (m_settle > 0) m_settle--;
          else if (!good) begin ns = 2; m_run = 0; m_goodrun = 0; end
          else begin
            m_goodrun++;
            if (m_goodrun == 64) begin ns = 4; m_goodrun = 0; m_loss = 0; m_spent = 0; end
          end
        end
      end
      4: begin
        if (i_rxsync != 8'(1 << m_shift)) m_loss++; else m_loss = 0;
        if (m_loss == 4) begin ns = 2; m_loss = 0; m_run = 0; end
        else if (!good) begin err = 1; if (m_errs < 65535) m_errs++; end
      end
      default: ns = 0;
    endcase
    if (m_st != 0) for (int i = 0; i < N; i++) m_prev[i] = int'(i_rx_dout[8*i +: 8]);
    m_pvld = (m_st != 0);
    m_pll1 = m_pll0; m_pll0 = i_pll_locked;
    m_st = ns;
    e_state = ns; e_srst = (ns == 0 || ns == 1); e_al = (ns == 4); e_err = err;
  endtask

  logic [7:0] lane_v[N];
  int corr_lane = 0;
  logic [7:0] corr_mask = 8'h00;

  // one clock: drive lanes, predict, clock, compare every output
  task automatic tick();
    for (int i = 0; i < N; i++)
      i_rx_dout[8*i +: 8] = lane_v[i] ^ ((i == corr_lane) ? corr_mask : 8'h00);
    model_step();
    @(posedge i_clk); @(negedge i_clk);
    cyc++;
    chk("state", 32'(o_state), 32'(e_state));
    chk("serdes_rst", 32'(o_serdes_rst), 32'(e_srst));
    chk("aligned", 32'(o_aligned), 32'(e_al));
    chk("error", 32'(o_error), 32'(e_err));
    chk("shift", 32'(o_shift), 32'(m_shift));
    chk("err_count", 32'(o_err_count), 32'(m_errs));
    chk("retry_count", 32'(o_retry_count), 32'(m_retries));
    for (int i = 0; i < N; i++) lane_v[i] = lane_v[i] + 8'd1;
    corr_mask = 8'h00;
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_state"}, 32'(o_state), 32'd0);
    chk({pfx, "_serdes_rst"}, 32'(o_serdes_rst), 32'd1);
    chk({pfx, "_shift"}, 32'(o_shift), 32'd0);
    chk({pfx, "_aligned"}, 32'(o_aligned), 32'd0);
    chk({pfx, "_error"}, 32'(o_error), 32'd0);
    chk({pfx, "_err_count"}, 32'(o_err_count), 32'd0);
    chk({pfx, "_retry_count"}, 32'(o_retry_count), 32'd0);
  endtask

  initial begin
    int t_s, t_c, t_l, t_r, n, nerr, sidx, r, glitch, pdrop;
    logic [11:0] seq;
    logic [2:0] last;
    i_rstn = 1'b0; i_pll_locked = 1'b0; i_retrain = 1'b0;
    i_rxsync = 8'h00; i_rx_dout = '0;
    for (int i = 0; i < N; i++) lane_v[i] = 8'h00;
    model_reset();
    repeat (2) @(negedge i_clk);
    chk_reset_vals("rst");

    // clean link: sync bit 2, lanes counting from 0
    i_rstn = 1'b1; i_pll_locked = 1'b1; i_rxsync = 8'h04;
    t_s = 0; t_c = 0; t_l = 0;
    for (int k = 0; k < 60 && o_state != 3'd2; k++) tick();
    t_s = cyc;
    for (int k = 0; k < 20 && o_state != 3'd3; k++) tick();
    t_c = cyc;
    for (int k = 0; k < 100 && o_state != 3'd4; k++) tick();
    t_l = cyc;
    chk("search_len", 32'(t_c - t_s), 32'd8);
    chk("check_len", 32'(t_l - t_c), 32'd68);
    chk("lock_shift", 32'(o_shift), 32'd2);

    // single corrupted word on lane 1 gives two miscompares
    corr_lane = 1; corr_mask = 8'h5A; nerr = 0;
    repeat (5) begin tick(); if (o_error) nerr++; end
    chk("err_pulses", 32'(nerr), 32'd2);
    chk("err_cnt_2", 32'(o_err_count), 32'd2);
    chk("aligned_hold", 32'(o_aligned), 32'd1);

    // three bad sync words are tolerated, four force a re-search
    i_rxsync = 8'h00; repeat (3) tick();
    i_rxsync = 8'h04; tick();
    chk("loss3_state", 32'(o_state), 32'd4);
    i_rxsync = 8'h00; repeat (4) tick();
    chk("loss4_state", 32'(o_state), 32'd2);
    chk("loss4_aligned", 32'(o_aligned), 32'd0);

    // retrain while in CHECK
    i_rxsync = 8'h04;
    for (int k = 0; k < 20 && o_state != 3'd3; k++) tick();
    i_retrain = 1'b1; tick(); i_retrain = 1'b0;
    chk("retrain_state", 32'(o_state), 32'd1);
    chk("retrain_errcnt", 32'(o_err_count), 32'd0);

    // alternating sync never locks; timeout after 1024 cycles of training
    for (int k = 0; k < 40 && o_state != 3'd2; k++) begin
      i_rxsync = ((cyc / 4) % 2) ? 8'h20 : 8'h02; tick();
    end
    t_s = cyc;
    for (int k = 0; k < 1100 && o_state != 3'd1; k++) begin
      i_rxsync = ((cyc / 4) % 2) ? 8'h20 : 8'h02; tick();
    end
    t_r = cyc;
    chk("timeout_len", 32'(t_r - t_s), 32'd1024);
    chk("timeout_retry", 32'(o_retry_count), 32'd1);

    // pll drop: hold low 20 cycles, then check reset hold and state order
    i_rxsync = 8'h04; i_pll_locked = 1'b0;
    repeat (20) tick();
    i_pll_locked = 1'b1;
    n = 0; seq = 12'(o_state); last = o_state;
    for (int k = 0; k < 60 && o_state != 3'd2; k++) begin
      tick();
      if (o_serdes_rst) n++;
      if (o_state != last) begin seq = (seq << 4) | 12'(o_state); last = o_state; end
    end
    chk("pll_rst_hold", 32'(n), 32'd18);
    chk("pll_seq", 32'(seq), 32'h012);
    chk("pll_retry_kept", 32'(o_retry_count), 32'd1);

    // random soak: random shift, lane data, glitches, retrains, pll drops
    glitch = 0; pdrop = 0; sidx = 0;
    for (int it = 0; it < 8; it++) begin
      sidx = $urandom_range(0, 7);
      for (int i = 0; i < N; i++) lane_v[i] = 8'($urandom);
      for (int k = 0; k < 250; k++) begin
        r = $urandom_range(0, 999);
        if (glitch > 0) begin i_rxsync = 8'($urandom_range(0, 255)); glitch--; end
        else begin
          i_rxsync = 8'(1 << sidx);
          if (r < 15) glitch = $urandom_range(1, 5);
        end
        if (r >= 15 && r < 35) begin
          corr_lane = $urandom_range(0, N - 1);
          corr_mask = 8'($urandom_range(1, 255));
        end
        i_retrain = (r == 500);
        i_pll_locked = (pdrop == 0);
        if (pdrop > 0) pdrop--;
        else if (r == 900) pdrop = $urandom_range(1, 5);
        tick();
      end
    end
    i_retrain = 1'b0; i_pll_locked = 1'b1;

    // async reset from LOCKED takes effect without a clock edge
    i_rxsync = 8'(1 << sidx);
    for (int k = 0; k < 2500 && o_state != 3'd4; k++) tick();
    chk("pre_rst_locked", 32'(o_state), 32'd4);
    #2 i_rstn = 1'b0;
    #1 chk_reset_vals("async");
    model_reset();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
